mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
- Round-robin arbiter and pipeline controller that time-shares one signed 16x16 multiplier among N_REQ requesters.
- Typical requesters: barycentric weight computation, attribute interpolation and depth interpolation in the rasterizer.
- Requesters present operands with a req/gnt handshake. The result returns one-hot-tagged two cycles after grant.
- Supports short locked bursts, so a requester can issue back-to-back products (e.g. three weights) without interleaving.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LOCK_MAX, 4, maximum consecutive grants one requester may hold via lock before it is forced to release (1..15).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; operands valid while high.
- lock  in  N_REQ  per-requester burst hold; only meaningful for the current grantee.
- a_in  in  16*N_REQ  signed operand A; slice i = [16i+15:16i].
- b_in  in  16*N_REQ  signed operand B, same slicing.
- gnt  out  N_REQ  combinational one-hot grant; operands of the granted slice are consumed at this edge.
- res_valid  out  N_REQ  registered one-hot; result belongs to requester i.
- res_data  out  32  registered signed full product a*b.
- busy  out  1  registered; high while any product is in the pipeline.
- op_count  out  16  registered count of granted operations; wraps 0xFFFF->0.

Behaviour:
- Reset (rst high at an edge), effective next cycle:
  - gnt=0, res_valid=0, res_data=0, busy=0, op_count=0.
  - Priority pointer=0, lock owner cleared, burst counter=0.
  - Pipeline valid bits are cleared. In-flight products are dropped and never reported.
  - gnt is forced 0 while rst is high.
- Arbitration, combinational within a cycle:
  - If a lock owner exists, it still has req high, and burst_cnt < LOCK_MAX, gnt goes to the owner.
  - Otherwise gnt goes to the first i with req[i]=1, searching pointer, pointer+1, ... mod N_REQ.
  - No request: gnt=0.
- Update at each edge with a grant to i:
  - Pointer <= (i+1) mod N_REQ.
  - Lock:
    - If lock[i]=1, owner <= i and burst_cnt <= burst_cnt+1, or 1 if i is a new owner.
    - Else owner is cleared and burst_cnt <= 0.
    - When burst_cnt reaches LOCK_MAX, the owner is cleared at that edge even if lock stays high. The next cycle arbitrates normally from pointer i+1.
  - op_count increments.
- Lock owner drops req: owner is cleared, and normal round-robin applies in the same cycle.
- Pipeline, throughput one product per cycle, no backpressure:
  - Stage 1, edge of grant: register A, B and the one-hot tag.
  - Stage 2, next edge: register A*B as a full 32-bit signed product, with the tag into res_valid.
  - Latency: gnt high in cycle t, so res_valid/res_data are valid in cycle t+2 for exactly one cycle.
  - Consumers must capture results when their res_valid bit is high.
- res_data holds its last value when res_valid=0.
- busy = OR of the stage-1 and stage-2 valid bits.
- Handshake rules:
  - A requester keeps req and its operands stable until it sees gnt.
  - Each gnt consumes exactly one operation.
  - To issue k products, a requester keeps req high for k grants and changes its operands after each grant.
  - A requester may drop req at any time before grant without side effects.
- Arithmetic: -32768*-32768 = 0x40000000, no saturation. Any fixed-point scaling is the requester's responsibility.
- Simultaneous events:
  - A new grant and a result return in the same cycle are independent.
  - lock asserted by a non-grantee is ignored.

Test Plan:
- Single requester: req[1]=1, a=0x0003, b=0xFFFE at cycle 0 → gnt=0010 in cycle 0; res_valid=0010 and res_data=0xFFFFFFFA in cycle 2; op_count=1.
- All four requesting continuously, no lock → grant order 0,1,2,3,0,1... with one grant per cycle; results return in the same order, 2 cycles after each grant.
- Burst: req[2] and lock[2] held, with req[0] also asserted, LOCK_MAX=4 → grants 2,2,2,2,0. Four results are tagged 0100, then one tagged 0001.
- Lock release: lock[2] dropped after 2 grants while req[3] pending → third grant goes to 3. Pointer then continues at 0.
- Extremes: a=b=0x8000 → 0x40000000; a=0x7FFF, b=0x8000 → 0xC0008000.
- Reset mid-flight: grant in cycle t, rst at edge t+1 → no res_valid in cycle t+2. All outputs 0, busy=0; after reset, req[3] alone is granted from pointer 0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Time-shares one signed 16x16 multiplier among N_REQ requesters. A
// round-robin arbiter picks one requester per cycle. The chosen operands
// enter a two-stage pipeline, and the full 32-bit product comes back with
// a one-hot tag two cycles after the grant. A requester can hold the grant
// for up to LOCK_MAX consecutive products by asserting its lock bit.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester request, operands valid while high
//   lock       per-requester burst hold (only the current grantee matters)
//   a_in/b_in  packed signed operands, slice i = [16i+15:16i]
//   gnt        combinational one-hot grant, operands consumed at this edge
//   res_valid  registered one-hot result tag
//   res_data   registered signed product, held while res_valid is 0
//   busy       registered, high while any product is in the pipeline
//   op_count   registered count of grants, wraps at 16 bits
module mult_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int LOCK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      lock,
  input  logic [16*N_REQ-1:0]   a_in,
  input  logic [16*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      res_valid,
  output logic [31:0]           res_data,
  output logic                  busy,
  output logic [15:0]           op_count
);

  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;
  localparam int PTR_W  = $clog2(N_REQ);
  localparam int CNT_W  = 4;

  // Full-precision signed product. Both operands are sign-extended to the
  // product width, so the low PROD_W bits of the product are exact and no
  // saturation is ever needed (-32768 * -32768 = 0x40000000 fits).
  function automatic logic signed [PROD_W-1:0] mul_full(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    a_ext = PROD_W'(a);
    b_ext = PROD_W'(b);
    return a_ext * b_ext;
  endfunction

  // Arbitration state
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              owner_vld_q, owner_vld_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [15:0]       op_count_q, op_count_d;

  // Pipeline state
  logic signed [DATA_W-1:0] a_p1_q, a_p1_d;
  logic signed [DATA_W-1:0] b_p1_q, b_p1_d;
  logic [N_REQ-1:0]         tag_p1_q, tag_p1_d;
  logic [N_REQ-1:0]         res_valid_q, res_valid_d;
  logic signed [PROD_W-1:0] res_data_q, res_data_d;
  logic                     busy_q, busy_d;

  // Arbiter combinational results
  logic [N_REQ-1:0]  gnt_vec;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_idx;
  logic              owner_hit;
  logic [CNT_W-1:0]  cnt_next;

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
  always_comb begin
    int idx;
    gnt_vec   = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    // A live lock owner bypasses round-robin until its burst budget is spent.
    owner_hit = owner_vld_q && req[owner_q] && (burst_cnt_q < CNT_W'(LOCK_MAX));
    if (!rst) begin
      if (owner_hit) begin
        gnt_any = 1'b1;
        gnt_idx = owner_q;
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = (int'(ptr_q) + k) % N_REQ;
          if (!gnt_any && req[PTR_W'(idx)]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(idx);
          end
        end
      end
      if (gnt_any) begin
        gnt_vec[gnt_idx] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pointer, lock ownership and operation counter
  // ---------------------------------------------------------------------
  always_comb begin
    ptr_d       = ptr_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    op_count_d  = op_count_q;
    cnt_next    = '0;
    if (gnt_any) begin
      ptr_d      = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      op_count_d = op_count_q + 16'd1;
      if (lock[gnt_idx]) begin
        // Continuing owner extends its burst; a new owner starts at 1.
        cnt_next = (owner_vld_q && (owner_q == gnt_idx)) ?
                   burst_cnt_q + CNT_W'(1) : CNT_W'(1);
        if (cnt_next >= CNT_W'(LOCK_MAX)) begin
          // Budget exhausted: release now so the next cycle is fair.
          owner_vld_d = 1'b0;
          burst_cnt_d = '0;
        end else begin
          owner_vld_d = 1'b1;
          owner_d     = gnt_idx;
          burst_cnt_d = cnt_next;
        end
      end else begin
        owner_vld_d = 1'b0;
        burst_cnt_d = '0;
      end
    end else if (owner_vld_q && !req[owner_q]) begin
      owner_vld_d = 1'b0;
      burst_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: capture granted operands and tag
  // ---------------------------------------------------------------------
  always_comb begin
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    tag_p1_d = gnt_vec;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vec[i]) begin
        a_p1_d = a_in[DATA_W*i +: DATA_W];
        b_p1_d = b_in[DATA_W*i +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: multiply, tag into res_valid
  // ---------------------------------------------------------------------
  always_comb begin
    res_valid_d = tag_p1_q;
    res_data_d  = res_data_q;
    if (|tag_p1_q) begin
      res_data_d = mul_full(a_p1_q, b_p1_q);
    end
    busy_d = (|tag_p1_d) | (|res_valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      op_count_q  <= '0;
      tag_p1_q    <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      op_count_q  <= op_count_d;
      tag_p1_q    <= tag_p1_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
  end

  // Operand registers carry no reset; their tag decides whether they matter.
  always_ff @(posedge clk) begin
    a_p1_q <= a_p1_d;
    b_p1_q <= b_p1_d;
  end

  assign gnt       = gnt_vec;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule
